// File: rtl/dcache_2way_param_if.sv
// Datapath and memory-side bus of the two-way data cache.
// master: datapath/memory environment, slave: the cache.
interface dcache_2way_param_if;
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  modport master (
    output halt, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dload, dwait,
    input  dhit, dmemload, flushed,
    input  dREN, dWEN, daddr, dstore
  );

  modport slave (
    input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dload, dwait,
    output dhit, dmemload, flushed,
    output dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_2way_param.sv
// Two-way set-associative write-back data cache with true LRU,
// burst fill/write-back, halt flush and hit-count store.
module dcache_2way_param #(
  parameter int          SETS        = 8,
  parameter int          WORDS       = 2,
  parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
  input logic CLK,
  input logic nRST,
  dcache_2way_param_if.slave bus
);
  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(SETS);
  localparam int KW = (OB > 0) ? OB : 1;
  localparam int TW = 30 - OB - IB;

  typedef logic [TW-1:0] tag_t;
  typedef logic [IB-1:0] idx_t;
  typedef logic [KW-1:0] k_t;

  typedef enum logic [2:0] {
    IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB, CNT, DONE
  } state_t;

  state_t state, nstate;

  tag_t        tags [2][SETS];
  logic [31:0] data [2][SETS][WORDS];
  logic [1:0][SETS-1:0] valid, dirty;
  logic [SETS-1:0] lru;

  k_t          k, nk;
  logic        vway;
  logic        sway, nsway;
  idx_t        sidx, nsidx;
  logic [31:0] hitcnt;
  logic        missed;

  idx_t idx;
  tag_t rtag;
  k_t   blk;
  logic req, h0, h1, hit, hway, vsel;
  logic do_hit, do_miss, last;
  logic scan_last, adv_sway;
  idx_t adv_sidx;

  function automatic logic [31:0] mkaddr(tag_t t, idx_t i, k_t kk);
    logic [31:0] a;
    a = {t, i, {(OB+2){1'b0}}};
    return a | {30'(kk) & 30'(WORDS-1), 2'b00};
  endfunction

  assign idx  = bus.dmemaddr[OB+2 +: IB];
  assign rtag = bus.dmemaddr[31 -: TW];
  assign blk  = k_t'(bus.dmemaddr[31:2] & 30'(WORDS-1));
  assign req  = bus.dmemREN | bus.dmemWEN;

  assign h0   = valid[0][idx] && (tags[0][idx] == rtag);
  assign h1   = valid[1][idx] && (tags[1][idx] == rtag);
  assign hit  = h0 | h1;
  assign hway = !h0;

  // Fill an empty way before evicting; otherwise evict the LRU way.
  assign vsel = !valid[0][idx] ? 1'b0 :
                !valid[1][idx] ? 1'b1 : lru[idx];

  assign do_hit  = (state == IDLE) && !bus.halt && req && hit;
  assign do_miss = (state == IDLE) && !bus.halt && req && !hit;
  assign last    = (k == k_t'(WORDS-1));

  assign scan_last = sway && (sidx == idx_t'(SETS-1));
  assign adv_sway  = sway ^ (sidx == idx_t'(SETS-1));
  assign adv_sidx  = sidx + idx_t'(1);

  always_comb begin
    nstate       = state;
    nk           = k;
    nsway        = sway;
    nsidx        = sidx;
    bus.dhit     = 1'b0;
    bus.dmemload = '0;
    bus.flushed  = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    unique case (state)
      IDLE: begin
        if (bus.halt) begin
          nstate = FLUSH_SCAN;
          nsway  = 1'b0;
          nsidx  = '0;
        end else if (do_hit) begin
          bus.dhit     = 1'b1;
          bus.dmemload = data[hway][idx][blk];
        end else if (do_miss) begin
          nk     = '0;
          nstate = (valid[vsel][idx] && dirty[vsel][idx]) ? WB : FILL;
        end
      end
      WB: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = mkaddr(tags[vway][idx], idx, k);
        bus.dstore = data[vway][idx][k];
        if (!bus.dwait) begin
          nk = last ? k_t'(0) : k + k_t'(1);
          if (last) nstate = FILL;
        end
      end
      FILL: begin
        bus.dREN  = 1'b1;
        bus.daddr = mkaddr(rtag, idx, k);
        if (!bus.dwait) begin
          nk = last ? k_t'(0) : k + k_t'(1);
          if (last) nstate = IDLE;
        end
      end
      FLUSH_SCAN: begin
        if (dirty[sway][sidx]) begin
          nstate = FLUSH_WB;
          nk     = '0;
        end else if (scan_last) begin
          nstate = CNT;
        end else begin
          nsway = adv_sway;
          nsidx = adv_sidx;
        end
      end
      FLUSH_WB: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = mkaddr(tags[sway][sidx], sidx, k);
        bus.dstore = data[sway][sidx][k];
        if (!bus.dwait) begin
          nk = last ? k_t'(0) : k + k_t'(1);
          if (last && scan_last) begin
            nstate = CNT;
          end else if (last) begin
            nstate = FLUSH_SCAN;
            nsway  = adv_sway;
            nsidx  = adv_sidx;
          end
        end
      end
      CNT: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = HITCNT_ADDR;
        bus.dstore = hitcnt;
        if (!bus.dwait) nstate = DONE;
      end
      DONE: bus.flushed = 1'b1;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= IDLE;
      k      <= '0;
      vway   <= 1'b0;
      sway   <= 1'b0;
      sidx   <= '0;
      hitcnt <= '0;
      missed <= 1'b0;
      valid  <= '0;
      dirty  <= '0;
      lru    <= '0;
    end else begin
      state <= nstate;
      k     <= nk;
      sway  <= nsway;
      sidx  <= nsidx;
      // Victim is invalidated up front so a partial fill never hits.
      if (do_miss) begin
        vway              <= vsel;
        missed            <= 1'b1;
        valid[vsel][idx]  <= 1'b0;
      end
      if (do_hit) begin
        lru[idx] <= !hway;
        missed   <= 1'b0;
        if (!missed) hitcnt <= hitcnt + 32'd1;
        if (bus.dmemWEN) dirty[hway][idx] <= 1'b1;
      end
      if (state == FILL && !bus.dwait && last) begin
        valid[vway][idx] <= 1'b1;
        dirty[vway][idx] <= 1'b0;
      end
      if (state == FLUSH_WB && !bus.dwait && last)
        dirty[sway][sidx] <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      if (do_hit && bus.dmemWEN)
        data[hway][idx][blk] <= bus.dmemstore;
      if (state == FILL && !bus.dwait) begin
        data[vway][idx][k] <= bus.dload;
        if (last) tags[vway][idx] <= rtag;
      end
    end
  end
endmodule

// File: tb/tb_dcache_2way_param.sv
// Bench for dcache_2way_param: vector table with memory-transaction
// scoreboard, plus flush and mid-fill reset sequences.
module tb_dcache_2way_param;
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  dcache_2way_param_if bus();

  dcache_2way_param #(
    .SETS(8), .WORDS(2), .HITCNT_ADDR(32'h0000_3100)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] load;
    logic        wb;
    logic [31:0] wba;
    logic [31:0] wbd0;
    logic [31:0] wbd1;
    logic [31:0] fa;
    int          lat;
  } vec_t;

  txn_t        q[$];
  txn_t        e;
  logic [31:0] mem [0:4095];
  int          n_chk = 0;
  int          n_pass = 0;
  int          lat = 0;
  int          wcnt = 0;
  int          cyc = 0;
  int          last_done = -10;
  logic        stall_prev = 1'b0;
  logic [65:0] prev;

  assign bus.dload = mem[bus.daddr[13:2]];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(posedge CLK) cyc++;

  // Memory model: dwait decided at negedge for the next rising edge.
  always @(negedge CLK) begin
    if (bus.dREN || bus.dWEN) begin
      if (stall_prev) begin
        n_chk++;
        if (prev == {bus.dREN, bus.dWEN, bus.daddr, bus.dstore}
            && !(bus.dREN && bus.dWEN))
          n_pass++;
        else
          $display("FAIL hold: got %h expected %h",
                   {bus.dREN, bus.dWEN, bus.daddr, bus.dstore}, prev);
      end
      if (wcnt >= lat) begin
        bus.dwait  = 1'b0;
        wcnt       = 0;
        stall_prev = 1'b0;
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL txn: got we=%0b addr=%h expected none",
                   bus.dWEN, bus.daddr);
        end else begin
          e = q.pop_front();
          if (e.we == bus.dWEN && e.addr == bus.daddr
              && (!e.we || e.data == bus.dstore))
            n_pass++;
          else
            $display("FAIL txn: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                     bus.dWEN, bus.daddr, bus.dstore, e.we, e.addr, e.data);
        end
        if (bus.dWEN) mem[bus.daddr[13:2]] = bus.dstore;
        last_done = cyc;
      end else begin
        bus.dwait  = 1'b1;
        wcnt++;
        stall_prev = 1'b1;
        prev       = {bus.dREN, bus.dWEN, bus.daddr, bus.dstore};
      end
    end else begin
      bus.dwait  = 1'b0;
      wcnt       = 0;
      stall_prev = 1'b0;
    end
  end

  task automatic apply(input vec_t v, input string nm);
    int n;
    int exp_n;
    lat = v.lat;
    if (!v.hit) begin
      if (v.wb) begin
        q.push_back('{1'b1, v.wba, v.wbd0});
        q.push_back('{1'b1, v.wba + 32'd4, v.wbd1});
      end
      q.push_back('{1'b0, v.fa, 32'h0});
      q.push_back('{1'b0, v.fa + 32'd4, 32'h0});
    end
    exp_n = v.hit ? 0 : 1 + (v.wb ? 4 : 2) * (v.lat + 1);
    @(negedge CLK);
    bus.dmemREN   = !v.wr;
    bus.dmemWEN   = v.wr;
    bus.dmemaddr  = v.addr;
    bus.dmemstore = v.wdata;
    n = 0;
    #1;
    while (!bus.dhit && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk({nm, "_dhit"}, 32'(bus.dhit), 32'd1);
    chk({nm, "_lat"}, n, exp_n);
    if (!v.wr) chk({nm, "_load"}, bus.dmemload, v.load);
    chk({nm, "_memq"}, q.size(), 0);
    @(negedge CLK);
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
  endtask

  vec_t vt[16];
  vec_t rv;

  initial begin
    int n;
    int exp_hits;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hD000_0000 | (i << 2);
    mem[32'h40 >> 2] = 32'hAAAA_0001;
    mem[32'h44 >> 2] = 32'hBBBB_0002;

    vt[0]  = '{0, 32'h40,  0, 0, 32'hAAAA0001, 0, 0, 0, 0, 32'h40, 0};
    vt[1]  = '{0, 32'h44,  0, 1, 32'hBBBB0002, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{1, 32'h40,  32'h12345678, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{0, 32'h40,  0, 1, 32'h12345678, 0, 0, 0, 0, 0, 0};
    vt[4]  = '{1, 32'h40,  32'h12345678, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[5]  = '{0, 32'h80,  0, 0, 32'hD0000080, 0, 0, 0, 0, 32'h80, 0};
    vt[6]  = '{0, 32'h80,  0, 1, 32'hD0000080, 0, 0, 0, 0, 0, 0};
    vt[7]  = '{0, 32'hC0,  0, 0, 32'hD00000C0, 1, 32'h40,
               32'h12345678, 32'hBBBB0002, 32'hC0, 0};
    vt[8]  = '{0, 32'h84,  0, 1, 32'hD0000084, 0, 0, 0, 0, 0, 0};
    vt[9]  = '{0, 32'h124, 0, 0, 32'hD0000124, 0, 0, 0, 0, 32'h120, 5};
    vt[10] = '{0, 32'h120, 0, 1, 32'hD0000120, 0, 0, 0, 0, 0, 0};
    vt[11] = '{1, 32'h08,  32'h08080808, 0, 0, 0, 0, 0, 0, 32'h08, 0};
    vt[12] = '{0, 32'h08,  0, 1, 32'h08080808, 0, 0, 0, 0, 0, 0};
    vt[13] = '{0, 32'h18,  0, 0, 32'hD0000018, 0, 0, 0, 0, 32'h18, 0};
    vt[14] = '{1, 32'h58,  32'h58585858, 0, 0, 0, 0, 0, 0, 32'h58, 0};
    vt[15] = '{0, 32'h5C,  0, 1, 32'hD000005C, 0, 0, 0, 0, 0, 0};

    nRST          = 1'b0;
    bus.halt      = 1'b0;
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_dhit", 32'(bus.dhit), 0);
    chk("rst_dmemload", bus.dmemload, 0);
    chk("rst_flushed", 32'(bus.flushed), 0);
    chk("rst_dren", 32'(bus.dREN), 0);
    chk("rst_dwen", 32'(bus.dWEN), 0);
    chk("rst_daddr", bus.daddr, 0);
    chk("rst_dstore", bus.dstore, 0);
    nRST = 1'b1;

    exp_hits = 0;
    for (int i = 0; i < 16; i++) begin
      apply(vt[i], $sformatf("v%0d", i));
      if (vt[i].hit) exp_hits++;
    end
    lat = 0;

    q.push_back('{1'b1, 32'h08,   32'h08080808});
    q.push_back('{1'b1, 32'h0C,   32'hD000000C});
    q.push_back('{1'b1, 32'h58,   32'h58585858});
    q.push_back('{1'b1, 32'h5C,   32'hD000005C});
    q.push_back('{1'b1, 32'h3100, 32'(exp_hits)});
    @(negedge CLK);
    bus.halt = 1'b1;
    n = 0;
    #1;
    while (!bus.flushed && n < 300) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("flush_flushed", 32'(bus.flushed), 1);
    chk("flush_memq", q.size(), 0);
    chk("flush_timing", cyc, last_done + 1);
    bus.halt = 1'b0;

    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      chk($sformatf("done_hold%0d", i),
          {28'h0, bus.dhit, bus.dREN, bus.dWEN, bus.flushed}, 32'h1);
    end
    bus.dmemREN = 1'b0;

    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("rst2_flushed", 32'(bus.flushed), 0);

    lat = 0;
    q.push_back('{1'b0, 32'h200, 32'h0});
    q.push_back('{1'b0, 32'h204, 32'h0});
    @(negedge CLK);
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h200;
    n = 0;
    #1;
    while (!(bus.dREN && bus.daddr == 32'h204) && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("midfill_word1", bus.daddr, 32'h204);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("midfill_rst_out", {29'h0, bus.dREN, bus.dWEN, bus.dhit}, 0);
    bus.dmemREN = 1'b0;
    chk("midfill_memq", q.size(), 0);

    rv = '{0, 32'h200, 0, 0, 32'hD0000200, 0, 0, 0, 0, 32'h200, 0};
    apply(rv, "refill");
    rv = '{0, 32'h204, 0, 1, 32'hD0000204, 0, 0, 0, 0, 0, 0};
    apply(rv, "refill_hit");

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
